// File: rtl/control_unit_mc_if.sv
// Control-unit <-> decoder/datapath bundle: instruction inputs, memory handshake, strobes, status.
// No latency of its own; carries only wires.
// The memory side holds mem_ready low to stretch an access; the control unit waits on it.
interface control_unit_mc_if #(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;
  logic                pc_en;
  logic                jmp;
  logic                ir_ld;
  logic                reg_wr;
  logic                alu_en;
  logic                mem_rd;
  logic                mem_wr;
  logic [1:0]          sel;
  logic                halted;
  logic                illegal;
  logic                bus_err;
  logic [CNT_W-1:0]    instr_cnt;
  logic [3:0]          pstate;
  logic [3:0]          nstate;

  // Control unit side
  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, jmp, ir_ld, reg_wr, alu_en, mem_rd, mem_wr, sel,
    output halted, illegal, bus_err, instr_cnt, pstate, nstate
  );

  // Decoder / datapath / memory side
  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, jmp, ir_ld, reg_wr, alu_en, mem_rd, mem_wr, sel,
    input  halted, illegal, bus_err, instr_cnt, pstate, nstate
  );
endinterface

// File: rtl/control_unit_mc.sv
// Multicycle control FSM: fetch/decode/execute sequencing with memory wait, traps and retire count.
// Strobes decode from present state (ir_ld/pc_en also follow mem_ready); nstate is combinational.
// Stalls in FETCH/IMM/LD/ST while mem_ready=0; traps to TRAP after MAX_WAIT stalled cycles.
module control_unit_mc #(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  control_unit_mc_if.master cu
);

  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_IMM    = 4'd3,
    S_LD     = 4'd4,
    S_EXEC   = 4'd5,
    S_ALU_WB = 4'd6,
    S_ST     = 4'd7,
    S_BR     = 4'd8,
    S_WB     = 4'd10,
    S_PC_INC = 4'd11,
    S_HALT   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  state_t             state;
  state_t             nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [1:0]         sel_wb;
  logic               halted_q;
  logic               illegal_q;
  logic               bus_err_q;
  logic [CNT_W-1:0]   instr_cnt_q;

  logic               is_wait;
  logic               timeout;
  logic               op_illegal;
  logic [3:0]         op_lo;

  assign op_lo      = cu.opcode[3:0];
  // Any set bit above the 4-bit opcode field, or the reserved code F, is illegal.
  assign op_illegal = ((cu.opcode >> 4) != '0) || (op_lo == 4'hF);
  assign is_wait    = (state == S_FETCH) || (state == S_IMM) || (state == S_LD) || (state == S_ST);
  // A ready arriving on the MAX_WAIT-th stalled cycle still completes the access.
  assign timeout    = (MAX_WAIT > 0) && (wait_cnt == WAIT_W'(MAX_WAIT)) && !cu.mem_ready;

  // Next-state selection; opcode/zero only matter in DECODE, mem_ready only in wait states.
  always_comb begin
    nxt = state;
    case (state)
      S_RST:    nxt = S_FETCH;
      S_FETCH, S_IMM, S_LD, S_ST: begin
        if (cu.mem_ready) begin
          case (state)
            S_FETCH: nxt = S_DECODE;
            S_IMM:   nxt = S_WB;
            S_LD:    nxt = S_WB;
            default: nxt = S_PC_INC;
          endcase
        end else if (timeout) begin
          nxt = S_TRAP;
        end
      end
      S_DECODE: begin
        if (op_illegal) begin
          nxt = S_TRAP;
        end else begin
          case (op_lo)
            4'h0:    nxt = S_PC_INC;
            4'h8:    nxt = S_BR;
            4'h9:    nxt = cu.zero ? S_BR : S_PC_INC;
            4'hA:    nxt = cu.zero ? S_PC_INC : S_BR;
            4'hB:    nxt = S_HALT;
            4'hC:    nxt = S_IMM;
            4'hD:    nxt = S_LD;
            4'hE:    nxt = S_ST;
            default: nxt = S_EXEC;
          endcase
        end
      end
      S_EXEC:   nxt = S_ALU_WB;
      S_ALU_WB: nxt = S_PC_INC;
      S_WB:     nxt = S_PC_INC;
      S_PC_INC: nxt = S_FETCH;
      S_BR:     nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_RST;
    endcase
  end

  // State, wait counter, write-back select, sticky status and retire counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_RST;
      wait_cnt    <= '0;
      sel_wb      <= 2'b00;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      state <= nxt;
      if (nxt != state) begin
        wait_cnt <= '0;
      end else if (is_wait && !cu.mem_ready && (wait_cnt != WAIT_W'(MAX_WAIT))) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if ((nxt == S_WB) && (state != S_WB)) begin
        sel_wb <= (state == S_IMM) ? 2'b10 : 2'b01;
      end
      if (nxt == S_HALT) begin
        halted_q <= 1'b1;
      end
      if ((state == S_DECODE) && (nxt == S_TRAP)) begin
        illegal_q <= 1'b1;
      end
      if (is_wait && (nxt == S_TRAP)) begin
        bus_err_q <= 1'b1;
      end
      if ((state == S_PC_INC) || (state == S_BR)) begin
        instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      end
    end
  end

  // Strobe decode from present state; ir_ld and the IMM pc_en follow mem_ready directly.
  always_comb begin
    cu.pc_en  = 1'b0;
    cu.jmp    = 1'b0;
    cu.ir_ld  = 1'b0;
    cu.reg_wr = 1'b0;
    cu.alu_en = 1'b0;
    cu.mem_rd = 1'b0;
    cu.mem_wr = 1'b0;
    cu.sel    = 2'b00;
    case (state)
      S_FETCH:  begin cu.mem_rd = 1'b1; cu.ir_ld = cu.mem_ready; end
      S_IMM:    begin cu.mem_rd = 1'b1; cu.pc_en = cu.mem_ready; end
      S_LD:     cu.mem_rd = 1'b1;
      S_ST:     cu.mem_wr = 1'b1;
      S_EXEC:   cu.alu_en = 1'b1;
      S_ALU_WB: cu.reg_wr = 1'b1;
      S_WB:     begin cu.reg_wr = 1'b1; cu.sel = sel_wb; end
      S_BR:     begin cu.pc_en = 1'b1; cu.jmp = 1'b1; end
      S_PC_INC: cu.pc_en = 1'b1;
      default:  ;
    endcase
  end

  assign cu.pstate    = state;
  // While reset is held every output, next-state included, reads as zero.
  assign cu.nstate    = reset ? nxt : S_RST;
  assign cu.halted    = halted_q;
  assign cu.illegal   = illegal_q;
  assign cu.bus_err   = bus_err_q;
  assign cu.instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_control_unit_mc.sv
// Bench for control_unit_mc: instruction-level path model feeds a per-cycle scoreboard.
// One expected vector per clock; monitor compares on the falling edge.
// Memory stalls are randomised, including stalls long enough to hit the timeout.
module tb_control_unit_mc;
  localparam int OW = 5;
  localparam int CW = 3;
  localparam int MW = 8;

  typedef struct packed {
    logic [3:0]    ps;
    logic [3:0]    ns;
    logic [6:0]    stb;   // {pc_en,jmp,ir_ld,reg_wr,alu_en,mem_rd,mem_wr}
    logic [1:0]    sel;
    logic [2:0]    flg;   // {halted,illegal,bus_err}
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  control_unit_mc_if #(.OPCODE_W(OW), .CNT_W(CW)) bus();
  control_unit_mc #(.OPCODE_W(OW), .CNT_W(CW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .cu(bus)
  );

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [CW-1:0] m_cnt = '0;
  logic        m_halted = 0, m_illegal = 0, m_buserr = 0;

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e, g;
    if (q.size() > 0) begin
      e = q.pop_front();
      g.ps = bus.pstate; g.ns = bus.nstate;
      g.stb = {bus.pc_en, bus.jmp, bus.ir_ld, bus.reg_wr, bus.alu_en, bus.mem_rd, bus.mem_wr};
      g.sel = bus.sel; g.flg = {bus.halted, bus.illegal, bus.bus_err}; g.cnt = bus.instr_cnt;
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL cycle_vec t=%0t got ps=%0d ns=%0d stb=%b sel=%b flg=%b cnt=%0d, expected ps=%0d ns=%0d stb=%b sel=%b flg=%b cnt=%0d",
                 $time, g.ps, g.ns, g.stb, g.sel, g.flg, g.cnt, e.ps, e.ns, e.stb, e.sel, e.flg, e.cnt);
      end
    end
  end

  // One clock of stimulus plus its expected outputs.
  task automatic step(input logic [3:0] ps, input logic [3:0] ns, input logic rdy,
                      input logic [OW-1:0] op, input logic z, input logic [6:0] stb,
                      input logic [1:0] sl, input logic rst_v);
    exp_t e;
    reset = rst_v; bus.mem_ready = rdy; bus.opcode = op; bus.zero = z;
    if (!rst_v) e = '0;
    else e = '{ps: ps, ns: ns, stb: stb, sel: sl, flg: {m_halted, m_illegal, m_buserr}, cnt: m_cnt};
    q.push_back(e);
    @(posedge clk); #1;
    if (rst_v && (ps == 4'd11 || ps == 4'd8)) m_cnt = m_cnt + 1'b1;
  endtask

  function automatic logic [OW-1:0] rop();
    return OW'($urandom);
  endfunction

  task automatic do_reset();
    m_cnt = '0; m_halted = 0; m_illegal = 0; m_buserr = 0;
    step(0, 0, 1'($urandom), rop(), 1'($urandom), 7'b0, 2'b00, 1'b0);
    step(0, 0, 1'($urandom), rop(), 1'($urandom), 7'b0, 2'b00, 1'b0);
    step(0, 1, 1'($urandom), rop(), 1'($urandom), 7'b0, 2'b00, 1'b1);
  endtask

  task automatic absorb(input logic [3:0] ps);
    repeat (3) step(ps, ps, 1'($urandom), rop(), 1'($urandom), 7'b0, 2'b00, 1'b1);
  endtask

  function automatic logic [6:0] acc_stb(input logic [3:0] ps, input logic rdy);
    case (ps)
      4'd1:    return {2'b00, rdy, 2'b00, 2'b10};
      4'd3:    return {rdy, 4'b0000, 2'b10};
      4'd4:    return 7'b0000010;
      default: return 7'b0000001;
    endcase
  endfunction

  // Memory access lasting 'waits' stalled cycles, timing out after MW stalls.
  task automatic access(input logic [3:0] ps, input int waits, input logic [3:0] after,
                        output bit trapped);
    trapped = 0;
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        step(ps, after, 1'b1, rop(), 1'($urandom), acc_stb(ps, 1'b1), 2'b00, 1'b1);
        return;
      end
      if (MW > 0 && i == MW) begin
        step(ps, 13, 1'b0, rop(), 1'($urandom), acc_stb(ps, 1'b0), 2'b00, 1'b1);
        m_buserr = 1;
        absorb(13);
        trapped = 1;
        return;
      end
      step(ps, ps, 1'b0, rop(), 1'($urandom), acc_stb(ps, 1'b0), 2'b00, 1'b1);
    end
  endtask

  task automatic pc_inc();
    step(11, 1, 1'($urandom), rop(), 1'($urandom), 7'b1000000, 2'b00, 1'b1);
  endtask

  // One instruction from fetch to retirement, following the documented state paths.
  task automatic do_instr(input logic [OW-1:0] op, input logic z, input int wf, input int wm,
                          output bit stopped);
    bit tr;
    logic [3:0] lo, nx;
    logic ill;
    stopped = 0;
    access(1, wf, 2, tr);
    if (tr) begin stopped = 1; return; end
    lo  = op[3:0];
    ill = (op >> 4) != 0 || lo == 4'hF;
    if (ill)                                   nx = 13;
    else if (lo == 0)                          nx = 11;
    else if (lo <= 7)                          nx = 5;
    else if (lo == 8)                          nx = 8;
    else if (lo == 9)                          nx = z ? 4'd8 : 4'd11;
    else if (lo == 4'hA)                       nx = z ? 4'd11 : 4'd8;
    else if (lo == 4'hB)                       nx = 12;
    else if (lo == 4'hC)                       nx = 3;
    else if (lo == 4'hD)                       nx = 4;
    else                                       nx = 7;
    step(2, nx, 1'($urandom), op, z, 7'b0, 2'b00, 1'b1);
    case (nx)
      4'd11: pc_inc();
      4'd5: begin
        step(5, 6, 1'($urandom), rop(), 1'($urandom), 7'b0000100, 2'b00, 1'b1);
        step(6, 11, 1'($urandom), rop(), 1'($urandom), 7'b0001000, 2'b00, 1'b1);
        pc_inc();
      end
      4'd3, 4'd4: begin
        access(nx, wm, 10, tr);
        if (tr) begin stopped = 1; return; end
        step(10, 11, 1'($urandom), rop(), 1'($urandom), 7'b0001000,
             (nx == 4'd3) ? 2'b10 : 2'b01, 1'b1);
        pc_inc();
      end
      4'd7: begin
        access(7, wm, 11, tr);
        if (tr) begin stopped = 1; return; end
        pc_inc();
      end
      4'd8: step(8, 1, 1'($urandom), rop(), 1'($urandom), 7'b1100000, 2'b00, 1'b1);
      4'd12: begin m_halted = 1; absorb(12); stopped = 1; end
      default: begin m_illegal = 1; absorb(13); stopped = 1; end
    endcase
  endtask

  function automatic int rwait();
    return ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(6, 11);
  endfunction

  initial begin
    bit st;
    logic [OW-1:0] op;
    bus.opcode = '0; bus.zero = 0; bus.mem_ready = 0;
    @(posedge clk); #1;
    do_reset();
    // Directed paths
    do_instr(5'h0C, 0, 0, 0, st);
    do_instr(5'h01, 1, 0, 0, st);
    do_instr(5'h0D, 0, 0, 3, st);
    do_instr(5'h09, 1, 0, 0, st);
    do_instr(5'h09, 0, 0, 0, st);
    do_instr(5'h0A, 0, 0, 0, st);
    do_instr(5'h0A, 1, 2, 0, st);
    do_instr(5'h0C, 0, 1, 8, st);
    do_instr(5'h0E, 0, 0, 20, st);
    do_reset();
    do_instr(5'h0F, 0, 0, 0, st);
    do_reset();
    do_instr(5'h10, 0, 0, 0, st);
    do_reset();
    do_instr(5'h0B, 0, 0, 0, st);
    do_reset();
    repeat (9) do_instr(5'h00, 0, 0, 0, st);
    do_instr(5'h07, 0, 20, 0, st);
    do_reset();
    // Reset while a store is about to start: nothing may complete.
    step(1, 2, 1'b1, rop(), 0, 7'b0010010, 2'b00, 1'b1);
    step(2, 7, 1'($urandom), 5'h0E, 0, 7'b0, 2'b00, 1'b1);
    do_reset();
    // Randomised mix
    for (int n = 0; n < 120; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 3)       op = 5'h10 | OW'($urandom_range(0, 15));
      else if (r < 5)  op = 5'h0B;
      else if (r < 7)  op = 5'h0F;
      else begin
        op = OW'($urandom_range(0, 14));
        if (op == 5'h0B) op = 5'h00;
      end
      do_instr(op, 1'($urandom), rwait(), rwait(), st);
      if (st) do_reset();
    end
    #10;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/control_unit_mc.md
Name: control_unit_mc

Overview:
- Parametrised multicycle control FSM, successor to the fixed 4-bit RISC-16 control unit.
- Sits between the instruction register/decoder and the datapath (PC, register file, ALU, memory port).
- Adds a memory ready/wait handshake with timeout, conditional branches on the zero flag, HALT, illegal-opcode trap and a retired-instruction counter.
- Exposes present and next state for debug.

Parameters:
OPCODE_W, 4, opcode input width; must be >= 4; any nonzero bit above bit 3 makes the opcode illegal
CNT_W, 16, width of the retired-instruction counter
MAX_WAIT, 8, maximum wait cycles per memory access before bus error; 0 disables the timeout

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
opcode  in  OPCODE_W  instruction opcode from IR, sampled in DECODE
zero  in  1  ALU zero flag, sampled in DECODE
mem_ready  in  1  memory access complete this cycle
pc_en  out  1  PC load/increment strobe
jmp  out  1  PC source = branch target
ir_ld  out  1  load IR from memory data
reg_wr  out  1  register file write enable
alu_en  out  1  ALU operation strobe
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
sel  out  2  write-back mux: 00 ALU, 01 memory data, 10 immediate
halted  out  1  core halted, sticky
illegal  out  1  illegal opcode trap, sticky
bus_err  out  1  memory timeout trap, sticky
instr_cnt  out  CNT_W  retired-instruction count
pstate  out  4  present state
nstate  out  4  next state (combinational)

Behaviour:
- States, 4-bit encoding: 0 RST, 1 FETCH, 2 DECODE, 3 IMM, 4 LD, 5 EXEC, 6 ALU_WB, 7 ST, 8 BR, 10 WB, 11 PC_INC, 12 HALT, 13 TRAP.
- Reset (reset=0, async):
  - pstate=RST.
  - All outputs 0, including instr_cnt, halted, illegal, bus_err and the wait counter.
  - RST -> FETCH unconditionally on the first clock after release.
- Opcode map (low 4 bits):
  - 0 NOP
  - 1-7 ALU ops
  - 8 JMP
  - 9 JZ
  - A JNZ
  - B HLT
  - C MVI
  - D LOAD
  - E STORE
  - F illegal
- Paths, each wait state shown with mem_ready=1:
  - NOP: 1,2,11
  - ALU: 1,2,5,6,11
  - MVI: 1,2,3,10,11
  - LOAD: 1,2,4,10,11
  - STORE: 1,2,7,11
  - JMP: 1,2,8,1
  - JZ with zero=1, or JNZ with zero=0: 1,2,8,1
  - Branch not taken: 1,2,11
  - HLT: 1,2,12
  - Illegal: 1,2,13
- Output decode (Moore on pstate unless noted):
  - FETCH: mem_rd=1; ir_ld = mem_ready.
  - IMM: mem_rd=1; pc_en = mem_ready (Mealy), stepping the PC past the immediate word.
  - LD: mem_rd=1.
  - ST: mem_wr=1.
  - EXEC: alu_en=1.
  - ALU_WB: reg_wr=1, sel=00.
  - WB: reg_wr=1; sel=10 if arrived from IMM, else 01. The selection is registered on entry.
  - BR: pc_en=1, jmp=1.
  - PC_INC: pc_en=1.
  - All other states drive every strobe to 0, with sel=00.
- Wait handshake:
  - In FETCH, IMM, LD and ST the FSM holds its state and request while mem_ready=0.
  - The wait counter clears on entering each wait state and increments on each cycle with mem_ready=0.
  - If MAX_WAIT>0 and the counter reaches MAX_WAIT with mem_ready still 0, next state is TRAP and bus_err is set.
  - mem_ready=1 in the same cycle the counter reaches MAX_WAIT wins: the access completes.
- Trap and halt:
  - HALT and TRAP are absorbing; only reset exits them.
  - halted=1 in HALT.
  - illegal is set on the DECODE->TRAP transition for an illegal opcode.
  - All strobes are 0 in both states.
- instr_cnt:
  - Increments by 1 on each clock leaving PC_INC or BR (one instruction retired) and wraps modulo 2^CNT_W.
  - HLT does not count.
- Signals outside their sampling states (opcode and zero outside DECODE, mem_ready outside wait states) are ignored.
- Reset asserted mid-instruction immediately forces RST and clears all outputs, with no partial write completing.

Test Plan:
1. Reset=0 for 2 cycles, release, hold mem_ready=1 and opcode=C -> pstate 0,1,2,3,10,11,1. WB has reg_wr=1, sel=10. pc_en is asserted in IMM and PC_INC. instr_cnt=1.
2. opcode=1 (ADD) with mem_ready=1 -> states 1,2,5,6,11. alu_en only in EXEC; reg_wr=1 with sel=00 only in ALU_WB.
3. opcode=D, mem_ready held 0 for 3 cycles in LD and MAX_WAIT=8 -> mem_rd stays 1 and pstate=4 for 4 cycles, then 10 (sel=01), then 11. bus_err=0.
4. opcode=E with mem_ready stuck 0 and MAX_WAIT=8 -> after 8 wait cycles pstate=13, bus_err=1, mem_wr drops to 0 and stays 0. A later reset pulse clears bus_err and returns to RST.
5. JZ with zero=1 -> 1,2,8,1 with pc_en=jmp=1 in BR. JZ with zero=0 -> 1,2,11. JNZ with zero=0 -> taken. instr_cnt increments for each.
6. opcode=F -> pstate=13, illegal=1. opcode=B -> pstate=12, halted=1, no further strobes. CNT_W=2 with 5 NOPs -> instr_cnt wraps to 1.
